// File: rtl/tmr_scrub_sched_if.sv
// Error collection / scrub request bundle between tmr_scrub_sched and the voted submodules.
interface tmr_scrub_sched_if #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned CNT_W = 8
);
    logic [N_SRC-1:0] err_i;
    logic [N_SRC-1:0] scrub_ack_i;
    logic             clr_i;
    logic [N_SRC-1:0] scrub_req_o;
    logic             busy_o;
    logic [N_SRC-1:0] status_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic             timeout_o;
    logic             err_o;

    modport master (
        output err_i, scrub_ack_i, clr_i,
        input  scrub_req_o, busy_o, status_o, err_cnt_o, timeout_o, err_o
    );

    modport slave (
        input  err_i, scrub_ack_i, clr_i,
        output scrub_req_o, busy_o, status_o, err_cnt_o, timeout_o, err_o
    );
endinterface

// File: rtl/tmr_scrub_sched.sv
// Round-robin scrub scheduler and aggregated error sink for voted submodule instances.
// Collects error pulses, serialises scrub requests, keeps sticky status and a saturating count.
module tmr_scrub_sched #(
    parameter int unsigned N_SRC   = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TMO_CYC = 15
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    tmr_scrub_sched_if.slave bus
);
    localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned TMO_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        COOL = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] status_q, status_d;
    logic [N_SRC-1:0] req_q, req_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;

    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] sel_nxt;
    logic [N_SRC-1:0] ack_clr;
    logic             tmo_set;
    logic             new_evt;

    // First pending source at or after rr_q, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            cand = IDX_W'((32'(rr_q) + i) % N_SRC);
            if (!grant_vld && pending_q[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign sel_nxt = (32'(sel_q) == N_SRC - 1) ? '0 : sel_q + IDX_W'(1);

    // Scheduler next state; ack beats timeout when both land in the same cycle.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        tmo_d   = tmo_q;
        req_d   = req_q;
        ack_clr = '0;
        tmo_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d = REQ;
                    sel_d   = grant_idx;
                    req_d   = N_SRC'(1) << grant_idx;
                    tmo_d   = '0;
                end
            end
            REQ: begin
                if (bus.scrub_ack_i[sel_q]) begin
                    ack_clr[sel_q] = 1'b1;
                    rr_d    = sel_nxt;
                    req_d   = '0;
                    state_d = COOL;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_set = 1'b1;
                    rr_d    = sel_nxt;
                    req_d   = '0;
                    state_d = COOL;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            COOL: begin
                tmo_d   = '0;
                req_d   = '0;
                state_d = IDLE;
            end
            default: begin
                req_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Pending/status bookkeeping; a new error always wins over ack or clear.
    always_comb begin
        pending_d = (pending_q & ~ack_clr) | bus.err_i;
        new_evt   = |(pending_d & ~pending_q);
        status_d  = (bus.clr_i ? '0 : status_q) | bus.err_i;
        timeout_d = (bus.clr_i ? 1'b0 : timeout_q) | tmo_set;
        cnt_d     = bus.clr_i ? '0 : cnt_q;
        if (new_evt && (cnt_d != CNT_MAX)) begin
            cnt_d = cnt_d + CNT_W'(1);
        end
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pending_q <= '0;
            status_q  <= '0;
            req_q     <= '0;
            rr_q      <= '0;
            sel_q     <= '0;
            tmo_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            status_q  <= status_d;
            req_q     <= req_d;
            rr_q      <= rr_d;
            sel_q     <= sel_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.scrub_req_o = req_q;
    assign bus.busy_o      = busy_q;
    assign bus.status_o    = status_q;
    assign bus.err_cnt_o   = cnt_q;
    assign bus.timeout_o   = timeout_q;
    assign bus.err_o       = (|status_q) | timeout_q;
endmodule

// File: tb/tb_tmr_scrub_sched.sv
// Self-checking bench for tmr_scrub_sched: directed scenarios plus random traffic
// against a behavioural scheduler model compared on every cycle.
module tb_tmr_scrub_sched;
    localparam int unsigned N   = 4;
    localparam int unsigned CW  = 2;
    localparam int unsigned TMO = 15;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tmr_scrub_sched_if #(.N_SRC(N), .CNT_W(CW)) bus ();

    tmr_scrub_sched #(.N_SRC(N), .CNT_W(CW), .TMO_CYC(TMO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending set, sticky status, count, and a grant slot (phase 0 idle, 1 req, 2 cool).
    logic [N-1:0] m_pend, m_stat;
    int           m_cnt, m_rr, m_g, m_age, m_phase;
    bit           m_tout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = '0; m_stat = '0; m_cnt = 0; m_tout = 1'b0;
            m_rr = 0; m_g = 0; m_age = 0; m_phase = 0;
        end else begin : model_step
            logic [N-1:0] np;
            bit acked, tmo_now;
            int pick;
            acked   = (m_phase == 1) && bus.scrub_ack_i[m_g];
            tmo_now = (m_phase == 1) && !acked && (m_age == TMO - 1);
            np = m_pend | bus.err_i;
            if (acked && !bus.err_i[m_g]) np[m_g] = 1'b0;
            if (bus.clr_i) begin
                m_stat = '0; m_cnt = 0; m_tout = 1'b0;
            end
            m_stat |= bus.err_i;
            if ((np & ~m_pend) != '0) m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
            if (tmo_now) m_tout = 1'b1;
            case (m_phase)
                0: if (m_pend != '0) begin
                    pick = 0;
                    for (int i = N - 1; i >= 0; i--)
                        if (m_pend[(m_rr + i) % N]) pick = (m_rr + i) % N;
                    m_g = pick; m_age = 0; m_phase = 1;
                end
                1: if (acked || tmo_now) begin
                    m_rr = (m_g + 1) % N; m_phase = 2;
                end else begin
                    m_age++;
                end
                default: m_phase = 0;
            endcase
            m_pend = np;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_scrub_req", bus.scrub_req_o, (m_phase == 1) ? (32'd1 << m_g) : 32'd0);
            chk("cyc_busy",      bus.busy_o,      (m_phase != 0) ? 32'd1 : 32'd0);
            chk("cyc_status",    bus.status_o,    m_stat);
            chk("cyc_err_cnt",   bus.err_cnt_o,   m_cnt);
            chk("cyc_timeout",   bus.timeout_o,   m_tout);
            chk("cyc_err",       bus.err_o,       ((m_stat != '0) || m_tout) ? 32'd1 : 32'd0);
        end
    end

    task automatic step(input logic [N-1:0] e, input logic [N-1:0] a, input logic c);
        bus.err_i = e; bus.scrub_ack_i = a; bus.clr_i = c;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},    bus.scrub_req_o, 0);
        chk({tag, "_busy"},   bus.busy_o,      0);
        chk({tag, "_status"}, bus.status_o,    0);
        chk({tag, "_cnt"},    bus.err_cnt_o,   0);
        chk({tag, "_tmo"},    bus.timeout_o,   0);
        chk({tag, "_err"},    bus.err_o,       0);
    endtask

    initial begin
        int n;
        int exp_cnt [5];
        logic [N-1:0] b, e, a;
        exp_cnt = '{1, 2, 3, 3, 3};
        bus.err_i = '0; bus.scrub_ack_i = '0; bus.clr_i = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Round-robin from rr_ptr = 0, one event cycle.
        step(4'b1111, '0, 1'b0);
        chk("rr_status", bus.status_o, 4'hF);
        chk("rr_err", bus.err_o, 1);
        step('0, '0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_grant%0d", k), bus.scrub_req_o, 32'd1 << k);
            step('0, N'(1 << k), 1'b0);
            chk("rr_cool_req", bus.scrub_req_o, 0);
            step('0, '0, 1'b0);
            step('0, '0, 1'b0);
        end
        chk("rr_cnt", bus.err_cnt_o, 1);
        step('0, '0, 1'b1);
        chk("rr_clr_status", bus.status_o, 0);

        // Single error, ack two cycles after the request rises.
        step(4'b0010, '0, 1'b0);
        chk("single_status", bus.status_o, 4'b0010);
        chk("single_err", bus.err_o, 1);
        chk("single_req_early", bus.scrub_req_o, 0);
        step('0, '0, 1'b0);
        chk("single_req", bus.scrub_req_o, 4'b0010);
        chk("single_busy", bus.busy_o, 1);
        step('0, '0, 1'b0);
        step('0, '0, 1'b0);
        chk("single_req_held", bus.scrub_req_o, 4'b0010);
        step('0, 4'b0010, 1'b0);
        chk("single_cool_req", bus.scrub_req_o, 0);
        chk("single_cool_busy", bus.busy_o, 1);
        step('0, '0, 1'b0);
        chk("single_idle_busy", bus.busy_o, 0);
        chk("single_cnt", bus.err_cnt_o, 1);
        step('0, '0, 1'b1);

        // Timeout on source 2, source 0 raised meanwhile.
        step(4'b0100, '0, 1'b0);
        step('0, '0, 1'b0);
        n = 0;
        while (bus.scrub_req_o == 4'b0100 && n < 40) begin
            n++;
            step((n == 3) ? 4'b0001 : 4'b0000, '0, 1'b0);
        end
        chk("tmo_held_cycles", n, TMO);
        chk("tmo_flag", bus.timeout_o, 1);
        chk("tmo_err", bus.err_o, 1);
        step('0, '0, 1'b0);
        step('0, '0, 1'b0);
        chk("tmo_next_grant", bus.scrub_req_o, 4'b0001);
        step('0, 4'b0001, 1'b0);
        step('0, '0, 1'b0);
        step('0, '0, 1'b0);
        chk("tmo_regrant", bus.scrub_req_o, 4'b0100);
        step('0, 4'b0100, 1'b0);
        idle(2);
        chk("tmo_cnt", bus.err_cnt_o, 2);
        step('0, '0, 1'b1);
        chk("tmo_clr", bus.timeout_o, 0);

        // Saturation of a 2-bit counter over five scrubbed events.
        for (int i = 0; i < 5; i++) begin
            b = N'(1 << (i % N));
            step(b, '0, 1'b0);
            chk($sformatf("sat_cnt%0d", i), bus.err_cnt_o, exp_cnt[i]);
            step('0, '0, 1'b0);
            chk($sformatf("sat_req%0d", i), bus.scrub_req_o, b);
            step('0, b, 1'b0);
            idle(2);
        end
        step('0, '0, 1'b1);
        chk("sat_clr_cnt", bus.err_cnt_o, 0);
        chk("sat_clr_status", bus.status_o, 0);
        chk("sat_clr_err", bus.err_o, 0);

        // New error on the ack cycle keeps the source pending.
        step(4'b0010, '0, 1'b0);
        step('0, '0, 1'b0);
        chk("sim_req", bus.scrub_req_o, 4'b0010);
        step(4'b0010, 4'b0010, 1'b0);
        step('0, '0, 1'b0);
        step('0, '0, 1'b0);
        chk("sim_regrant", bus.scrub_req_o, 4'b0010);
        chk("sim_cnt", bus.err_cnt_o, 1);
        step('0, 4'b0010, 1'b0);
        idle(2);
        step(4'b1000, '0, 1'b1);
        chk("clr_evt_status", bus.status_o, 4'b1000);
        chk("clr_evt_cnt", bus.err_cnt_o, 1);
        step('0, '0, 1'b0);
        step('0, 4'b1000, 1'b0);
        idle(2);

        // Async reset while a request is up; rr_ptr moved to 1 beforehand.
        step(4'b0001, '0, 1'b0);
        step('0, '0, 1'b0);
        step('0, 4'b0001, 1'b0);
        idle(2);
        step(4'b0100, '0, 1'b0);
        step('0, '0, 1'b0);
        chk("arst_req_before", bus.scrub_req_o, 4'b0100);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("arst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step('0, '0, 1'b0);
            chk("arst_no_replay", bus.scrub_req_o, 0);
        end
        step(4'b0011, '0, 1'b0);
        step('0, '0, 1'b0);
        chk("arst_rr_zero", bus.scrub_req_o, 4'b0001);
        step('0, 4'b0001, 1'b0);
        idle(2);
        step('0, 4'b0010, 1'b0);
        idle(2);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            e = '0;
            a = '0;
            for (int i = 0; i < N; i++) if ($urandom_range(9) == 0) e[i] = 1'b1;
            if (m_phase == 1 && $urandom_range(2) == 0) a[m_g] = 1'b1;
            if ($urandom_range(7) == 0) a[$urandom_range(N - 1)] ^= 1'b1;
            step(e, a, ($urandom_range(49) == 0));
        end
        step('0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
